// File: rtl/bsg_dff_pipe_pkg.sv
// rtl/bsg_dff_pipe_pkg.sv - shared constants and count-width helper for the reset pipe
package bsg_dff_pipe_pkg;

    // Default payload width and stage count for bsg_dff_pipe_reset
    localparam int default_width_lp = 3;
    localparam int default_depth_lp = 2;

    // Bits needed to hold an occupancy count from 0 to depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bsg_dff_pipe_reset_stage.sv
// rtl/bsg_dff_pipe_reset_stage.sv - one valid+data pipe register with async reset, load and clear
module bsg_dff_pipe_reset_stage #(
    parameter int                 width_p     = 3,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);

    logic               v_q;
    logic               v_d;
    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    // Next state: clear drops valid only; a load takes the upstream valid and
    // only overwrites the data bits when that upstream item is real
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (clear_i) begin
            v_d = 1'b0;
        end else if (en_i) begin
            v_d = v_i;
            if (v_i) begin
                data_d = data_i;
            end
        end
    end

    // Stage register; reset acts immediately, independent of the clock
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= reset_val_p;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;

endmodule

// File: rtl/bsg_dff_pipe_reset.sv
// rtl/bsg_dff_pipe_reset.sv - bubble-collapsing valid/ready register pipe; BSG_DFF_PIPE_RESET_COUNT_EN adds count_o
module bsg_dff_pipe_reset
    import bsg_dff_pipe_pkg::*;
#(
    parameter int                 width_p     = default_width_lp,
    parameter int                 depth_p     = default_depth_lp,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              clear_i,
    input  logic                              v_i,
    input  logic [width_p-1:0]                data_i,
    output logic                              ready_o,
    input  logic                              yumi_i,
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
    output logic [count_width(depth_p)-1:0]   count_o,
`endif
    output logic                              v_o,
    output logic [width_p-1:0]                data_o
);

    logic [depth_p-1:0] stage_v;
    logic [depth_p-1:0] stage_en;
    logic [depth_p-1:0] fill_v;
    logic [width_p-1:0] stage_data [depth_p];
    logic [width_p-1:0] fill_data  [depth_p];

    // A stage can take new contents when the output is being consumed or some
    // stage at or beyond it is empty; that hole lets everything behind it shift
    // forward by one, which is what collapses bubbles.
    for (genvar k = 0; k < depth_p; k++) begin : g_stage
        assign stage_en[k] = yumi_i | ~(&stage_v[depth_p-1:k]);

        if (k == 0) begin : g_head
            assign fill_v[k]    = v_i;
            assign fill_data[k] = data_i;
        end else begin : g_body
            assign fill_v[k]    = stage_v[k-1];
            assign fill_data[k] = stage_data[k-1];
        end

        bsg_dff_pipe_reset_stage #(
            .width_p    (width_p),
            .reset_val_p(reset_val_p)
        ) u_stage (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .clear_i(clear_i),
            .en_i   (stage_en[k]),
            .v_i    (fill_v[k]),
            .data_i (fill_data[k]),
            .v_o    (stage_v[k]),
            .data_o (stage_data[k])
        );
    end

    // The head loads whenever it can take contents, so that is also the accept
    // condition; held low during reset so nothing is offered as accepted then.
    assign ready_o = stage_en[0] & ~reset_i;

    assign v_o    = stage_v[depth_p-1];
    assign data_o = stage_data[depth_p-1];

`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
    localparam int count_w_lp = count_width(depth_p);

    logic [count_w_lp-1:0] count_q;
    logic [count_w_lp-1:0] count_d;

    // Occupancy after this edge: sum of each stage's next valid bit
    always_comb begin
        count_d = '0;
        if (!clear_i) begin
            for (int k = 0; k < depth_p; k++) begin
                if (stage_en[k] ? fill_v[k] : stage_v[k]) begin
                    count_d = count_d + count_w_lp'(1);
                end
            end
        end
    end

    // Occupancy register, tracking the stage valid bits edge for edge
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_bsg_dff_pipe_reset.sv
// tb/tb_bsg_dff_pipe_reset.sv - self-checking bench for bsg_dff_pipe_reset
module tb_bsg_dff_pipe_reset;

    localparam int         W  = 8;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'h3C;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear_i, v_i, yumi_i, ready_o, v_o;
    logic [7:0] data_i, data_o;
    logic       b_clear, b_v, b_yumi, b_ready, b_vo;
    logic [7:0] b_data, b_data_o;
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
    logic [1:0] count_o;
    logic [0:0] b_count;
`endif

    always #5 clk = ~clk;

    bsg_dff_pipe_reset #(.width_p(W), .depth_p(D), .reset_val_p(RV)) dut (
        .clk_i(clk), .reset_i(rst), .clear_i(clear_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .yumi_i(yumi_i),
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
        .count_o(count_o),
`endif
        .v_o(v_o), .data_o(data_o)
    );

    bsg_dff_pipe_reset #(.width_p(8), .depth_p(1), .reset_val_p(8'h00)) dut1 (
        .clk_i(clk), .reset_i(rst), .clear_i(b_clear), .v_i(b_v), .data_i(b_data),
        .ready_o(b_ready), .yumi_i(b_yumi),
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
        .count_o(b_count),
`endif
        .v_o(b_vo), .data_o(b_data_o)
    );

    int ntest;
    int nfail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: ordered list of items in flight, each with its distance from the input
    typedef struct {
        logic [7:0] d;
        int         pos;
    } item_t;

    item_t      mq[$];
    item_t      nq[$];
    int         np[$];
    logic [7:0] mout = RV;
    logic [7:0] got[$];
    bit         m_rdy;

    // Each item steps one position closer to the output if the slot ahead is
    // free after the item in front has moved; -1 marks an item consumed
    function automatic void compute_moves(input bit y);
        int limit;
        int p;
        np.delete();
        limit = D - 1;
        foreach (mq[i]) begin
            if (i == 0 && mq[i].pos == D - 1 && y) begin
                np.push_back(-1);
            end else begin
                p = (mq[i].pos < limit) ? mq[i].pos + 1 : mq[i].pos;
                np.push_back(p);
                limit = p - 1;
            end
        end
    endfunction

    function automatic bit model_ready(input bit y);
        compute_moves(y);
        if (mq.size() == 0) return 1'b1;
        return np[np.size()-1] != 0;
    endfunction

    function automatic bit model_v();
        return mq.size() > 0 && mq[0].pos == D - 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mout = RV;
        end else if (clear_i) begin
            mq.delete();
        end else begin
            m_rdy = model_ready(yumi_i);
            nq.delete();
            foreach (mq[i]) begin
                if (np[i] >= 0) begin
                    nq.push_back('{mq[i].d, np[i]});
                    if (np[i] == D - 1 && mq[i].pos != D - 1) mout = mq[i].d;
                end
            end
            if (v_i && m_rdy) begin
                nq.push_back('{data_i, 0});
                if (D - 1 == 0) mout = data_i;
            end
            mq = nq;
        end
    end

    always @(negedge clk) begin
        check("v_o", 32'(v_o), 32'(model_v()));
        check("data_o", 32'(data_o), 32'(mout));
        check("ready_o", 32'(ready_o), 32'(rst ? 1'b0 : model_ready(yumi_i)));
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
        check("count_o", 32'(count_o), 32'(mq.size()));
`endif
        if (!rst && v_o && yumi_i) got.push_back(data_o);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit y_en, input bit clr);
        v_i     = v;
        data_i  = d;
        yumi_i  = y_en & model_v();
        clear_i = clr;
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit y_en, input bit clr);
        drive(v, d, y_en, clr);
        tick();
    endtask

    int rdy_low;

    initial begin
        ntest = 0; nfail = 0;
        rst = 1'b1; clear_i = 0; v_i = 0; data_i = 0; yumi_i = 0;
        b_clear = 0; b_v = 0; b_data = 0; b_yumi = 0;
        #1;
        check("rst_v_o", 32'(v_o), 0);
        check("rst_data_o", 32'(data_o), 32'h3C);
        check("rst_ready_o", 32'(ready_o), 0);
        check("rst_b_ready", 32'(b_ready), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("ready_after_rst", 32'(ready_o), 1);
        check("b_ready_after_rst", 32'(b_ready), 1);

        // single item latency
        step(1, 8'hA5, 1, 0);
        step(0, 0, 1, 0);
        check("lat_t1_v", 32'(v_o), 0);
        step(0, 0, 1, 0);
        check("lat_t2_v", 32'(v_o), 1);
        check("lat_t2_data", 32'(data_o), 32'hA5);
        step(0, 0, 1, 0);
        check("lat_t3_v", 32'(v_o), 0);
        check("lat_t3_data_kept", 32'(data_o), 32'hA5);

        // streaming at full rate
        got.delete();
        rdy_low = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1, 8'(i), 1, 0);
            #1;
            if (!ready_o) rdy_low++;
            tick();
        end
        repeat (4) step(0, 0, 1, 0);
        check("stream_ready_low", 32'(rdy_low), 0);
        check("stream_count", 32'(got.size()), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", 32'(got[i]), 32'(i + 1));

        // fill without consumer, then pop and push together
        got.delete();
        step(1, 8'h21, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h23, 0, 0);
        check("full_ready", 32'(ready_o), 0);
        step(1, 8'h24, 0, 0);
        check("full_ready_hold", 32'(ready_o), 0);
        check("full_frozen_data", 32'(data_o), 32'h21);
        drive(1, 8'h24, 1, 0);
        #1;
        check("pop_push_ready", 32'(ready_o), 1);
        tick();
        check("pop_push_v", 32'(v_o), 1);
        check("pop_push_data", 32'(data_o), 32'h22);
        repeat (4) step(0, 0, 1, 0);
        check("order_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("order_data", 32'(got[i]), 32'(8'h21 + i));

        // clear with a simultaneous push and pop
        step(1, 8'h31, 0, 0);
        step(1, 8'h32, 0, 0);
        step(1, 8'h33, 0, 0);
        step(0, 0, 1, 0);
        check("pre_clr_v", 32'(v_o), 1);
        check("pre_clr_data", 32'(data_o), 32'h32);
        step(1, 8'h77, 1, 1);
        check("clr_v", 32'(v_o), 0);
        check("clr_data_kept", 32'(data_o), 32'h32);
`ifdef BSG_DFF_PIPE_RESET_COUNT_EN
        check("clr_count", 32'(count_o), 0);
`endif
        got.delete();
        repeat (4) step(0, 0, 1, 0);
        check("clr_nothing_out", 32'(got.size()), 0);

        // asynchronous reset pulse mid-stream
        step(1, 8'h41, 1, 0);
        step(1, 8'h42, 1, 0);
        step(1, 8'h43, 1, 0);
        drive(1, 8'h44, 1, 0);
        #1;
        rst = 1'b1; v_i = 0; yumi_i = 0;
        #1;
        check("async_rst_v", 32'(v_o), 0);
        check("async_rst_data", 32'(data_o), 32'h3C);
        check("async_rst_ready", 32'(ready_o), 0);
        rst = 1'b0;
        got.delete();
        repeat (5) step(0, 0, 1, 0);
        check("rst_no_old_items", 32'(got.size()), 0);
        check("rst_data_hold", 32'(data_o), 32'h3C);

        // depth 1: alternating push and pop
        drive(0, 0, 0, 0);
        b_v = 1; b_data = 8'h11; b_yumi = 0;
        #1 check("d1_ready_empty", 32'(b_ready), 1);
        tick();
        check("d1_v_a", 32'(b_vo), 1);
        check("d1_data_a", 32'(b_data_o), 32'h11);
        b_v = 1; b_data = 8'h12; b_yumi = 0;
        #1 check("d1_ready_full", 32'(b_ready), 0);
        tick();
        check("d1_frozen", 32'(b_data_o), 32'h11);
        b_v = 0; b_yumi = 1;
        #1 check("d1_ready_pop", 32'(b_ready), 1);
        tick();
        check("d1_v_b", 32'(b_vo), 0);
        check("d1_data_kept", 32'(b_data_o), 32'h11);
        b_v = 1; b_data = 8'h22; b_yumi = 0;
        tick();
        check("d1_v_c", 32'(b_vo), 1);
        check("d1_data_c", 32'(b_data_o), 32'h22);
        b_v = 1; b_data = 8'h33; b_yumi = 1;
        #1 check("d1_ready_pushpop", 32'(b_ready), 1);
        tick();
        check("d1_v_d", 32'(b_vo), 1);
        check("d1_data_d", 32'(b_data_o), 32'h33);
        b_v = 0; b_yumi = 1;
        tick();
        check("d1_v_e", 32'(b_vo), 0);
        b_yumi = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/bsg_dff_pipe_reset.md
BSG_DFF_PIPE_RESET -- requirements
Module: bsg_dff_pipe_reset

Interface
REQ-001 Parameter width_p, default 3: payload width in bits; SHALL be >= 1.
REQ-002 Parameter depth_p, default 2: number of register stages; SHALL be >= 1.
REQ-003 Parameter reset_val_p, default 0 (width_p bits): value loaded into every data stage on reset.
REQ-004 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset_i  input  1  asynchronous, active-high reset.
REQ-006 clear_i  input  1  synchronous flush of all stages.
REQ-007 v_i  input  1  upstream data valid.
REQ-008 data_i  input  width_p  upstream payload.
REQ-009 ready_o  output  1  block accepts data_i this cycle.
REQ-010 v_o  output  1  data_o holds a valid item.
REQ-011 data_o  output  width_p  payload of the output stage (stage depth_p-1).
REQ-012 yumi_i  input  1  downstream consumes data_o this cycle; SHALL only be asserted when v_o=1.

Function
REQ-013 Each stage k SHALL hold data[k] and valid[k]; stage 0 faces the input, stage depth_p-1 drives v_o/data_o directly from flops.
REQ-014 Stage depth_p-1 SHALL advance when yumi_i=1 or it is empty; stage k<depth_p-1 SHALL advance when stage k+1 advances or stage k+1 is empty (bubble collapsing).
REQ-015 ready_o SHALL be 1 when stage 0 is empty or stage 0 advances, and 0 while reset_i=1.
REQ-016 An item is accepted when v_i & ready_o; it SHALL load stage 0 at that edge.
REQ-017 On an empty pipe, an item accepted at edge t SHALL be visible on data_o with v_o=1 after edge t+depth_p-1 (depth_p cycles of latency counting the accept cycle).
REQ-018 Sustained throughput SHALL be one item per cycle when v_i=1 and yumi_i=1 continuously.
REQ-019 Items SHALL leave in acceptance order; no item SHALL be dropped or duplicated.
REQ-020 A stage that does not advance, or advances with no incoming valid item, SHALL keep its data bits unchanged (valid cleared only on advance-without-fill).
REQ-021 clear_i=1 SHALL clear every valid bit at the next edge and SHALL take precedence over a simultaneous accept or yumi_i; data bits SHALL be left unchanged.
REQ-022 Full pipe (all valid) with yumi_i=0: ready_o=0, contents frozen.
REQ-023 Full pipe with yumi_i=1 and v_i=1: pop and push in the same cycle, stays full.

Reset
REQ-024 reset_i=1 SHALL immediately, without a clock edge, clear all valid bits and load reset_val_p into all data stages.
REQ-025 Reset values: v_o=0, data_o=reset_val_p, ready_o=0 during reset, 1 in the first cycle after deassertion.
REQ-026 Reset asserted mid-transfer SHALL discard all in-flight items; none SHALL reappear after release.

Configuration
REQ-027 Macro BSG_DFF_PIPE_RESET_COUNT_EN defined: add output count_o, width $clog2(depth_p+1), equal to the number of valid stages, registered, reset to 0, cleared by clear_i.
REQ-028 Macro undefined: count_o port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package bsg_dff_pipe_pkg SHALL hold the count-width helper function and the default width/depth constants.
REQ-030 One sub-module bsg_dff_pipe_reset_stage (one valid+data register with async reset, load and clear) SHALL be instantiated depth_p times.

Verification
REQ-031 width_p=8, depth_p=3: accept 0xA5 on empty pipe, yumi_i=1 -> v_o=1, data_o=0xA5 exactly 3 cycles after accept, then v_o=0.
REQ-032 depth_p=3: stream 0x01..0x10 with v_i=1, yumi_i=1 -> ready_o stays 1, outputs 0x01..0x10 in order, one per cycle.
REQ-033 depth_p=3, yumi_i=0, push 4 items -> ready_o=0 after 3rd; 4th not accepted; then yumi_i=1 -> 4th accepted the same cycle, order preserved.
REQ-034 Pipe holding 2 items, clear_i=1 with v_i=1 -> next cycle v_o=0, count_o=0 (COUNT_EN), new item not taken.
REQ-035 reset_val_p=0x3C, reset_i pulsed mid-stream between clock edges -> data_o=0x3C and v_o=0 immediately; no old items after release.
REQ-036 depth_p=1: alternating push/pop -> v_o toggles, data matches, ready_o=1 whenever yumi_i=1.
